dsram_responder: RTL
====================

Name: dsram_responder

Overview:
- Memory-side responder for the data-SRAM request interface driven by the memory-access pipeline stage.
- Accepts one request at a time: chip enable, write enable, 4-bit byte select, word address and write data.
- Holds a word-organised, big-endian, byte-writable storage array and inserts a configurable number of wait cycles.
- Drives read data, a one-cycle ready pulse and a stall to the pipeline controller.

Parameters:
- ADDR_W, 10, word-index width; storage depth = 2**ADDR_W words.
- WAIT_CYCLES, 1, extra wait cycles before the access is performed (0..15).
- CNT_W, 4, wait-counter width; must hold WAIT_CYCLES.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ce_i  in  1  request valid (chip enable).
- mem_we_i  in  1  1 = write, 0 = read.
- mem_sel_i  in  4  byte enables, write only: bit3 = bits 31:24 = byte offset 0; bit0 = bits 7:0 = byte offset 3.
- mem_addr_i  in  32  byte address; word index = mem_addr_i[ADDR_W+1:2]; bits 1:0 and the upper bits are ignored.
- mem_data_i  in  32  write data, already lane-replicated by the initiator.
- mem_data_o  out  32  read data; valid while ready_o = 1 and held afterwards.
- ready_o  out  1  one-cycle completion pulse.
- stall_o  out  1  pipeline must hold the request.

Behaviour:
- Reset values:
  - State IDLE, counter 0, request latches 0.
  - mem_data_o = 0, ready_o = 0, stall_o = 0.
  - Storage array is not cleared.
- Reset mid-operation:
  - Returns to IDLE at the next edge.
  - A latched write not yet performed is discarded; no partial write occurs.
- FSM states:
  - IDLE:
    - At an edge with mem_ce_i = 1, latch we, sel, word index and wdata.
    - Load counter with WAIT_CYCLES and go to WAIT.
  - WAIT:
    - If counter != 0, decrement.
    - If counter == 0, perform the access at this edge and go to RESP.
    - Read: mem_data_o <= array[idx], full word; sel is ignored.
    - Write: for each sel bit = 1, update that byte lane only.
    - Write: mem_data_o is unchanged.
  - RESP:
    - ready_o = 1 for this cycle only.
    - If mem_ce_i = 1 at this edge, latch a new request and go to WAIT (back-to-back).
    - Otherwise go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0.
  - Access edge ends cycle WAIT_CYCLES+1.
  - ready_o is high in cycle WAIT_CYCLES+2.
  - With WAIT_CYCLES = 0, ready_o is high in cycle 2.
- stall_o (combinational):
  - 1 when state == WAIT, or when state == IDLE and mem_ce_i = 1.
  - 0 in RESP and when rst = 1.
  - The pipeline releases the request in the cycle ready_o = 1.
- Request stability: the initiator's inputs may change after the sampling edge; only latched values are used.
- sel = 0000 on a write: no byte is modified; full handshake still completes.
- Address aliasing: addresses beyond the depth wrap by truncation, with no error.
- Read-after-write to the same word, back-to-back: the read returns the merged, written data (sequential, not bypassed).
- ready_o and stall_o are never both 1.

Decomposition:
- Shared package:
  - State encoding IDLE/WAIT/RESP.
  - Byte-lane index constants (lane 3 = offset 0).
  - Reuse the codebase's existing ChipEnable, WriteEnable, RstEnable and ZeroWord constants.
- Sub-module dsram_byte_array: the 2**ADDR_W x 32 storage with a 4-bit byte write enable and a synchronous read port.
- The FSM, counter and request latch live in the top module.

Test Plan:
- Reset, then idle with mem_ce_i = 0 for 5 cycles -> ready_o = 0, stall_o = 0, mem_data_o = 0x00000000.
- Write full word: addr 0x00000010, sel 1111, data 0xDEADBEEF, WAIT_CYCLES = 1 -> stall_o = 1 in cycles 0–2, ready_o = 1 in cycle 3 only. Then read 0x00000010 -> mem_data_o = 0xDEADBEEF in that read's ready cycle.
- Byte write, in sequence:
  - Initialise word 0x20 to 0x11223344.
  - Write addr 0x21, sel 0100, data 0xAAAAAAAA -> subsequent read of 0x20 returns 0x11AA3344.
  - Then write with sel 0000 -> the read still returns 0x11AA3344.
- Back-to-back requests:
  - Keep mem_ce_i = 1 through RESP with a read following a write to the same word -> no IDLE cycle between them.
  - The read returns the newly written data.
  - ready_o pulses once per request.
- Reset mid-operation: assert rst during WAIT of a write of 0x55555555 to word 0x30 (previous value 0x0BADF00D) -> FSM returns to IDLE; a later read of word 0x30 returns 0x0BADF00D.
- Aliasing, ADDR_W = 10: write 0x12345678 to 0x00001004 -> a read of 0x00000004 returns 0x12345678.

Source files
------------

// File: rtl/dsram_responder_pkg.sv
// ---------------------------------------------------------------------------
// dsram_responder_pkg
// Definitions shared by the data-SRAM responder and its storage array.
//   - state_t       : responder FSM states (IDLE / WAIT / RESP)
//   - LANE_OFFn     : byte-lane index of big-endian byte offset n
//                     (offset 0 is bits 31:24, which is lane 3)
//   - ChipEnable, WriteEnable, RstEnable, ZeroWord : the codebase's
//     existing interface constants
// ---------------------------------------------------------------------------
package dsram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    // Big-endian layout: the lowest byte offset sits in the most
    // significant lane, so sel bit n enables lane n (bits 8n+7:8n).
    localparam int LANE_OFF0 = 3;
    localparam int LANE_OFF1 = 2;
    localparam int LANE_OFF2 = 1;
    localparam int LANE_OFF3 = 0;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/dsram_byte_array.sv
// ---------------------------------------------------------------------------
// dsram_byte_array
// Word-organised storage, 2**ADDR_W x 32 bits, split into four independent
// byte-wide lanes so that each lane maps onto its own block RAM with a
// simple write enable.
//   clk    : clock
//   rst    : synchronous active-high reset (clears the read register only;
//            the storage contents survive reset)
//   wr_en  : per-lane write enable, bit n writes bits 8n+7:8n
//   rd_en  : load the read register with the addressed word
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data, held until the next read or reset
// ---------------------------------------------------------------------------
module dsram_byte_array
    import dsram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANES-1:0]  wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_mem [DEPTH];
            logic [BYTE_W-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    lane_mem[addr] <= wdata[gi*BYTE_W +: BYTE_W];
                end
            end

            // Output register with synchronous reset; maps onto the
            // RAM's own output register.
            always_ff @(posedge clk) begin
                if (rst == RstEnable) begin
                    rd_reg <= '0;
                end else if (rd_en) begin
                    rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*BYTE_W +: BYTE_W] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dsram_responder.sv
// ---------------------------------------------------------------------------
// dsram_responder
// Memory-side responder for the data-SRAM request interface of the
// memory-access pipeline stage. One request is accepted at a time, held in
// a request latch, delayed by WAIT_CYCLES wait cycles, then performed on a
// byte-writable big-endian storage array.
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   mem_ce_i   : request valid
//   mem_we_i   : 1 = write, 0 = read
//   mem_sel_i  : byte enables for writes (bit3 = bits 31:24 = offset 0)
//   mem_addr_i : byte address, word index = mem_addr_i[ADDR_W+1:2]
//   mem_data_i : write data (already lane-replicated)
//   mem_data_o : read data, valid with ready_o and held afterwards
//   ready_o    : one-cycle completion pulse
//   stall_o    : pipeline must hold its request
// WAIT_CYCLES must fit in CNT_W bits.
// ---------------------------------------------------------------------------
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        ready_o,
    output logic        stall_o
);

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic                we_reg;
    logic [LANES-1:0]    sel_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [31:0]         wdata_reg;

    logic                req_accept;
    logic                access;
    logic [LANES-1:0]    ram_wr_en;
    logic                ram_rd_en;

    // Byte offset and the address bits above the storage depth play no
    // part: words alias by truncation.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_ce_i == ChipEnable) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Back-to-back: a request present during the ready cycle is
                // taken directly, skipping IDLE.
                state_next = (mem_ce_i == ChipEnable) ? ST_WAIT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        stall_o    = 1'b0;
        ready_o    = 1'b0;
        req_accept = 1'b0;
        access     = 1'b0;
        if (rst != RstEnable) begin
            case (state_reg)
                ST_IDLE: begin
                    stall_o    = (mem_ce_i == ChipEnable);
                    req_accept = (mem_ce_i == ChipEnable);
                end
                ST_WAIT: begin
                    stall_o = 1'b1;
                    access  = (cnt_reg == '0);
                end
                ST_RESP: begin
                    ready_o    = 1'b1;
                    req_accept = (mem_ce_i == ChipEnable);
                end
                default: ;
            endcase
        end
    end

    // access is already suppressed during reset, so an aborted write never
    // reaches the array.
    assign ram_wr_en = (access && we_reg == WriteEnable) ? sel_reg : '0;
    assign ram_rd_en = access && (we_reg != WriteEnable);

    // ---------------- request latch and wait counter ----------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            idx_reg   <= '0;
            wdata_reg <= ZeroWord;
        end else if (req_accept) begin
            cnt_reg   <= CNT_W'(WAIT_CYCLES);
            we_reg    <= mem_we_i;
            sel_reg   <= mem_sel_i;
            idx_reg   <= mem_addr_i[ADDR_W+1:2];
            wdata_reg <= mem_data_i;
        end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // ---------------- storage ----------------
    dsram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (ram_wr_en),
        .rd_en (ram_rd_en),
        .addr  (idx_reg),
        .wdata (wdata_reg),
        .rdata (mem_data_o)
    );

endmodule
